// File: rtl/svc_axi_tgen_ctrl.sv
// Run controller for the AXI traffic generator: sequences write/read bursts over many iterations.
// Optional per-phase cycle counters are enabled with `define SVC_AXI_TGEN_CTRL_PERF_EN.
module svc_axi_tgen_ctrl #(
    parameter int unsigned AXI_ADDR_WIDTH = 20,
    parameter int unsigned AXI_ID_WIDTH   = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,

    input  logic                      start,
    input  logic                      abort,
    input  logic [1:0]                mode,
    input  logic [15:0]               iterations,

    input  logic [AXI_ADDR_WIDTH-1:0] base_addr,
    input  logic [AXI_ADDR_WIDTH-1:0] iter_step,
    input  logic [AXI_ID_WIDTH-1:0]   burst_id,
    input  logic [7:0]                burst_beats,
    input  logic [AXI_ADDR_WIDTH-1:0] burst_stride,
    input  logic [2:0]                burst_size,
    input  logic [15:0]               burst_num,

    output logic                      w_start,
    output logic                      r_start,
    input  logic                      tgen_busy,
    output logic [AXI_ADDR_WIDTH-1:0] w_base_addr,
    output logic [AXI_ADDR_WIDTH-1:0] r_base_addr,
    output logic [AXI_ID_WIDTH-1:0]   w_burst_id,
    output logic [AXI_ID_WIDTH-1:0]   r_burst_id,
    output logic [7:0]                w_burst_beats,
    output logic [7:0]                r_burst_beats,
    output logic [AXI_ADDR_WIDTH-1:0] w_burst_stride,
    output logic [AXI_ADDR_WIDTH-1:0] r_burst_stride,
    output logic [2:0]                w_burst_awsize,
    output logic [2:0]                r_burst_arsize,
    output logic [15:0]               w_burst_num,
    output logic [15:0]               r_burst_num,

    output logic                      busy,
    output logic                      done,
    output logic                      aborted,
    output logic [15:0]               iter_count,
    output logic [31:0]               w_cycles,
    output logic [31:0]               r_cycles
);

    localparam int unsigned ITER_W  = 16;
    localparam int unsigned BEATS_W = 8;
    localparam int unsigned SIZE_W  = 3;
    localparam int unsigned MODE_W  = 2;

    localparam logic [MODE_W-1:0] MODE_WR   = 2'd0;
    localparam logic [MODE_W-1:0] MODE_RD   = 2'd1;
    localparam logic [MODE_W-1:0] MODE_WTR  = 2'd2;
    localparam logic [MODE_W-1:0] MODE_CONC = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LAUNCH = 3'd1,
        S_WAIT   = 3'd2,
        S_NEXT   = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;

    logic [MODE_W-1:0]         r_mode;
    logic [ITER_W-1:0]         r_iterations;
    logic [AXI_ADDR_WIDTH-1:0] r_iter_step;
    logic [AXI_ADDR_WIDTH-1:0] r_cur_addr;
    logic [AXI_ID_WIDTH-1:0]   r_cfg_id;
    logic [BEATS_W-1:0]        r_cfg_beats;
    logic [AXI_ADDR_WIDTH-1:0] r_cfg_stride;
    logic [SIZE_W-1:0]         r_cfg_size;
    logic [ITER_W-1:0]         r_cfg_num;

    logic                      r_phase_rd;
    logic                      r_wait_first;
    logic                      r_abort;
    logic                      r_wr_go;
    logic                      r_rd_go;
    logic                      r_busy;
    logic                      r_done;
    logic [ITER_W-1:0]         r_iter_count;

    logic                      w_accept;
    logic                      w_abort_any;
    logic                      w_wait_exit;
    logic                      w_last_iter;
    logic                      w_iter_full;
    logic [MODE_W-1:0]         w_mode_eff;
    logic                      w_phase_rd_nxt;
    logic                      w_wr_go_nxt;
    logic                      w_rd_go_nxt;

    assign w_accept    = (r_state == S_IDLE) && start;
    // An abort seen in the same cycle as a decision must already steer it.
    assign w_abort_any = r_abort || (abort && (r_state != S_IDLE));
    assign w_wait_exit = (r_state == S_WAIT) && !r_wait_first && !tgen_busy;
    assign w_last_iter = ((17'(r_iter_count) + 17'd1) == 17'(r_iterations));
    // A write-then-read iteration only counts once its read phase has run.
    assign w_iter_full = (r_mode != MODE_WTR) || r_phase_rd;
    assign w_mode_eff  = (r_state == S_IDLE) ? mode : r_mode;

    // Next-state and next start-pulse decode.
    always_comb begin
        w_state_nxt    = r_state;
        w_phase_rd_nxt = r_phase_rd;
        w_wr_go_nxt    = 1'b0;
        w_rd_go_nxt    = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_phase_rd_nxt = 1'b0;
                    w_state_nxt    = (iterations == '0) ? S_DONE : S_LAUNCH;
                end
            end
            S_LAUNCH: w_state_nxt = S_WAIT;
            S_WAIT: begin
                if (w_wait_exit) begin
                    if ((r_mode == MODE_WTR) && !r_phase_rd && !w_abort_any) begin
                        w_phase_rd_nxt = 1'b1;
                        w_state_nxt    = S_LAUNCH;
                    end else begin
                        w_state_nxt = S_NEXT;
                    end
                end
            end
            S_NEXT: begin
                w_phase_rd_nxt = 1'b0;
                w_state_nxt    = (w_last_iter || w_abort_any) ? S_DONE : S_LAUNCH;
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase

        if (w_state_nxt == S_LAUNCH) begin
            w_wr_go_nxt = (w_mode_eff == MODE_WR) || (w_mode_eff == MODE_CONC) ||
                          ((w_mode_eff == MODE_WTR) && !w_phase_rd_nxt);
            w_rd_go_nxt = (w_mode_eff == MODE_RD) || (w_mode_eff == MODE_CONC) ||
                          ((w_mode_eff == MODE_WTR) && w_phase_rd_nxt);
        end
    end

    // State register and registered control outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_phase_rd   <= 1'b0;
            r_wait_first <= 1'b0;
            r_wr_go      <= 1'b0;
            r_rd_go      <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_phase_rd   <= w_phase_rd_nxt;
            r_wait_first <= (r_state == S_LAUNCH);
            r_wr_go      <= w_wr_go_nxt;
            r_rd_go      <= w_rd_go_nxt;
            r_busy       <= (w_state_nxt != S_IDLE);
            r_done       <= (w_state_nxt == S_DONE);
        end
    end

    // Run configuration, current address, iteration count and abort flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mode       <= '0;
            r_iterations <= '0;
            r_iter_step  <= '0;
            r_cur_addr   <= '0;
            r_cfg_id     <= '0;
            r_cfg_beats  <= '0;
            r_cfg_stride <= '0;
            r_cfg_size   <= '0;
            r_cfg_num    <= '0;
            r_iter_count <= '0;
            r_abort      <= 1'b0;
        end else if (w_accept) begin
            r_mode       <= mode;
            r_iterations <= iterations;
            r_iter_step  <= iter_step;
            r_cur_addr   <= base_addr;
            r_cfg_id     <= burst_id;
            r_cfg_beats  <= burst_beats;
            r_cfg_stride <= burst_stride;
            r_cfg_size   <= burst_size;
            r_cfg_num    <= burst_num;
            r_iter_count <= '0;
            r_abort      <= 1'b0;
        end else begin
            if (abort && (r_state != S_IDLE)) begin
                r_abort <= 1'b1;
            end
            if (r_state == S_NEXT) begin
                if (w_iter_full && (r_iter_count != 16'hFFFF)) begin
                    r_iter_count <= r_iter_count + 16'd1;
                end
                if (w_state_nxt == S_LAUNCH) begin
                    r_cur_addr <= r_cur_addr + r_iter_step;
                end
            end
        end
    end

`ifdef SVC_AXI_TGEN_CTRL_PERF_EN
    logic        w_wr_phase;
    logic        w_rd_phase;
    logic [31:0] r_w_cyc;
    logic [31:0] r_r_cyc;

    assign w_wr_phase = (r_mode == MODE_WR) || (r_mode == MODE_CONC) ||
                        ((r_mode == MODE_WTR) && !r_phase_rd);
    assign w_rd_phase = (r_mode == MODE_RD) || (r_mode == MODE_CONC) ||
                        ((r_mode == MODE_WTR) && r_phase_rd);

    // Saturating WAIT-cycle counters, split by phase direction.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_w_cyc <= '0;
            r_r_cyc <= '0;
        end else if (w_accept) begin
            r_w_cyc <= '0;
            r_r_cyc <= '0;
        end else if (r_state == S_WAIT) begin
            if (w_wr_phase && (r_w_cyc != 32'hFFFF_FFFF)) begin
                r_w_cyc <= r_w_cyc + 32'd1;
            end
            if (w_rd_phase && (r_r_cyc != 32'hFFFF_FFFF)) begin
                r_r_cyc <= r_r_cyc + 32'd1;
            end
        end
    end

    assign w_cycles = r_w_cyc;
    assign r_cycles = r_r_cyc;
`else
    assign w_cycles = '0;
    assign r_cycles = '0;
`endif

    assign w_start        = r_wr_go;
    assign r_start        = r_rd_go;
    assign w_base_addr    = r_cur_addr;
    assign r_base_addr    = r_cur_addr;
    assign w_burst_id     = r_cfg_id;
    assign r_burst_id     = r_cfg_id;
    assign w_burst_beats  = r_cfg_beats;
    assign r_burst_beats  = r_cfg_beats;
    assign w_burst_stride = r_cfg_stride;
    assign r_burst_stride = r_cfg_stride;
    assign w_burst_awsize = r_cfg_size;
    assign r_burst_arsize = r_cfg_size;
    assign w_burst_num    = r_cfg_num;
    assign r_burst_num    = r_cfg_num;
    assign busy           = r_busy;
    assign done           = r_done;
    assign aborted        = r_abort;
    assign iter_count     = r_iter_count;

endmodule

// File: tb/tb_svc_axi_tgen_ctrl.sv
// Table-driven bench for svc_axi_tgen_ctrl with a simple generator busy model.
module tb_svc_axi_tgen_ctrl;

`ifdef SVC_AXI_TGEN_CTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, abort;
    logic [1:0]  mode;
    logic [15:0] iterations;
    logic [19:0] base_addr, iter_step, burst_stride;
    logic [3:0]  burst_id;
    logic [7:0]  burst_beats;
    logic [2:0]  burst_size;
    logic [15:0] burst_num;
    logic        w_start, r_start, tgen_busy;
    logic [19:0] w_base_addr, r_base_addr, w_burst_stride, r_burst_stride;
    logic [3:0]  w_burst_id, r_burst_id;
    logic [7:0]  w_burst_beats, r_burst_beats;
    logic [2:0]  w_burst_awsize, r_burst_arsize;
    logic [15:0] w_burst_num, r_burst_num;
    logic        busy, done, aborted;
    logic [15:0] iter_count;
    logic [31:0] w_cycles, r_cycles;

    int total = 0;
    int bad   = 0;
    int blen  = 1;
    int cnt;

    svc_axi_tgen_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mode(mode),
        .iterations(iterations), .base_addr(base_addr), .iter_step(iter_step),
        .burst_id(burst_id), .burst_beats(burst_beats), .burst_stride(burst_stride),
        .burst_size(burst_size), .burst_num(burst_num),
        .w_start(w_start), .r_start(r_start), .tgen_busy(tgen_busy),
        .w_base_addr(w_base_addr), .r_base_addr(r_base_addr),
        .w_burst_id(w_burst_id), .r_burst_id(r_burst_id),
        .w_burst_beats(w_burst_beats), .r_burst_beats(r_burst_beats),
        .w_burst_stride(w_burst_stride), .r_burst_stride(r_burst_stride),
        .w_burst_awsize(w_burst_awsize), .r_burst_arsize(r_burst_arsize),
        .w_burst_num(w_burst_num), .r_burst_num(r_burst_num),
        .busy(busy), .done(done), .aborted(aborted), .iter_count(iter_count),
        .w_cycles(w_cycles), .r_cycles(r_cycles)
    );

    always #5 clk = ~clk;

    // Generator model: busy rises with the start pulse and stays up blen cycles in total.
    always @(posedge clk) begin
        if (!rst_n)                                 cnt <= 0;
        else if ((w_start || r_start) && blen > 0)  cnt <= blen - 1;
        else if (cnt != 0)                          cnt <= cnt - 1;
    end
    assign tgen_busy = w_start || r_start || (cnt != 0);

    typedef struct {
        logic [1:0]  mode;
        int          iters;
        logic [19:0] base;
        logic [19:0] step;
        int          blen;
        int          abort_at;
        int          restart_at;
        bit          abort_ws;
        int          exp_busy;
        logic [15:0] exp_seq;
        logic [31:0] exp_sum;
        int          exp_iter;
        bit          exp_ab;
        int          exp_wc;
        int          exp_rc;
    } vec_t;

    vec_t vt[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        logic [3:0]  s_id;
        logic [7:0]  s_beats;
        logic [19:0] s_stride;
        logic [2:0]  s_size;
        logic [15:0] s_num;
        logic [15:0] seq;
        logic [31:0] sum;
        int          bc, dcnt;
        bit          cfg_ok, ended;
        string       p;

        p        = $sformatf("row%0d", idx);
        s_id     = 4'(idx + 1);
        s_beats  = 8'(16 * idx + 3);
        s_stride = 20'(idx * 'h100 + 'h40);
        s_size   = 3'(idx);
        s_num    = 16'(idx * 7 + 1);

        @(negedge clk);
        blen = v.blen;
        mode = v.mode; iterations = 16'(v.iters); base_addr = v.base; iter_step = v.step;
        burst_id = s_id; burst_beats = s_beats; burst_stride = s_stride;
        burst_size = s_size; burst_num = s_num;
        start = 1'b1; abort = v.abort_ws;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        // Scramble inputs so only latched values can reach the outputs.
        mode = ~mode; iterations = ~iterations; base_addr = ~base_addr; iter_step = ~iter_step;
        burst_id = ~burst_id; burst_beats = ~burst_beats; burst_stride = ~burst_stride;
        burst_size = ~burst_size; burst_num = ~burst_num;

        bc = 0; dcnt = 0; seq = '0; sum = '0; cfg_ok = 1'b1; ended = 1'b0;
        for (int c = 0; c < 300; c++) begin
            if (!busy) begin
                ended = 1'b1;
                break;
            end
            bc++;
            if (w_start || r_start) begin
                seq = {seq[13:0], w_start, r_start};
                sum = sum + (w_start ? 32'(w_base_addr) : 32'(r_base_addr));
                if (w_burst_id != s_id || r_burst_id != s_id || w_burst_beats != s_beats ||
                    r_burst_beats != s_beats || w_burst_stride != s_stride ||
                    r_burst_stride != s_stride || w_burst_awsize != s_size ||
                    r_burst_arsize != s_size || w_burst_num != s_num || r_burst_num != s_num)
                    cfg_ok = 1'b0;
            end
            if (done) dcnt++;
            abort = (bc == v.abort_at);
            start = (bc == v.restart_at);
            @(negedge clk);
        end
        abort = 1'b0; start = 1'b0;

        chk({p, " ended"},       64'(ended), 64'd1);
        chk({p, " busy_cycles"}, 64'(bc), 64'(v.exp_busy));
        chk({p, " start_seq"},   64'(seq), 64'(v.exp_seq));
        chk({p, " addr_sum"},    64'(sum), 64'(v.exp_sum));
        chk({p, " cfg_out"},     64'(cfg_ok), 64'd1);
        chk({p, " done_pulses"}, 64'(dcnt), 64'd1);
        chk({p, " iter_count"},  64'(iter_count), 64'(v.exp_iter));
        chk({p, " aborted"},     64'(aborted), 64'(v.exp_ab));
        chk({p, " w_cycles"},    64'(w_cycles), PERF ? 64'(v.exp_wc) : 64'd0);
        chk({p, " r_cycles"},    64'(r_cycles), PERF ? 64'(v.exp_rc) : 64'd0);
        repeat (3) @(negedge clk);
        chk({p, " iter_hold"},   64'(iter_count), 64'(v.exp_iter));
    endtask

    initial begin
        int nstarts, nbusy;
        // mode iters base step blen abort_at restart_at abort_ws | busy seq sum iter ab wc rc
        vt[0] = '{2'd0, 3, 20'h00100, 20'h00040, 5, 0, 0, 1'b0, 22, 16'h002A, 32'h3C0,   3, 1'b0, 15, 0};
        vt[1] = '{2'd1, 2, 20'h02000, 20'h00100, 3, 0, 0, 1'b0, 11, 16'h0005, 32'h4100,  2, 1'b0, 0,  6};
        vt[2] = '{2'd2, 2, 20'h00010, 20'h00008, 2, 0, 0, 1'b1, 15, 16'h0099, 32'h50,    2, 1'b0, 4,  4};
        vt[3] = '{2'd3, 1, 20'h00500, 20'h00010, 4, 0, 3, 1'b0, 7,  16'h0003, 32'h500,   1, 1'b0, 4,  4};
        vt[4] = '{2'd0, 2, 20'hFFFC0, 20'h00040, 2, 0, 0, 1'b0, 9,  16'h000A, 32'hFFFC0, 2, 1'b0, 4,  0};
        vt[5] = '{2'd1, 1, 20'h00000, 20'h00000, 1, 0, 0, 1'b0, 5,  16'h0001, 32'h0,     1, 1'b0, 0,  2};
        vt[6] = '{2'd0, 0, 20'h00123, 20'h00001, 3, 0, 0, 1'b0, 1,  16'h0000, 32'h0,     0, 1'b0, 0,  0};
        vt[7] = '{2'd2, 5, 20'h00300, 20'h00040, 5, 3, 5, 1'b0, 8,  16'h0002, 32'h300,   0, 1'b1, 5,  0};
        vt[8] = '{2'd0, 4, 20'h00000, 20'h00004, 2, 5, 0, 1'b0, 9,  16'h000A, 32'h4,     2, 1'b1, 4,  0};
        vt[9] = '{2'd2, 3, 20'h00040, 20'h00040, 2, 4, 0, 1'b0, 8,  16'h0009, 32'h80,    1, 1'b1, 2,  2};

        rst_n = 1'b0; start = 1'b0; abort = 1'b0; mode = '0; iterations = '0;
        base_addr = '0; iter_step = '0; burst_id = '0; burst_beats = '0;
        burst_stride = '0; burst_size = '0; burst_num = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        chk("reset busy_done",  64'({busy, done}), 64'd0);
        chk("reset starts",     64'({w_start, r_start}), 64'd0);
        chk("reset status",     64'({aborted, iter_count}), 64'd0);
        chk("reset cycles",     {w_cycles, r_cycles}, 64'd0);
        chk("reset w_cfg",      64'({w_base_addr, w_burst_id, w_burst_beats, w_burst_awsize, w_burst_num}), 64'd0);
        chk("reset r_cfg",      64'({r_base_addr, r_burst_id, r_burst_beats, r_burst_arsize, r_burst_num}), 64'd0);
        chk("reset strides",    64'({w_burst_stride, r_burst_stride}), 64'd0);

        for (int i = 0; i < 10; i++) run_vec(vt[i], i);

        // Reset in the middle of a concurrent run must kill it without further starts.
        @(negedge clk);
        blen = 3; mode = 2'd3; iterations = 16'd5; base_addr = 20'h00700; iter_step = 20'h10;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("midrun busy_before", 64'(busy), 64'd1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrun reset_outs", 64'({busy, done, w_start, r_start, aborted, iter_count, w_base_addr}), 64'd0);
        rst_n = 1'b1;
        nstarts = 0; nbusy = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (w_start || r_start) nstarts++;
            if (busy) nbusy++;
        end
        chk("midrun no_starts", 64'(nstarts), 64'd0);
        chk("midrun stay_idle", 64'(nbusy), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/svc_axi_tgen_ctrl.md
SVC_AXI_TGEN_CTRL -- requirements
Module: svc_axi_tgen_ctrl

Interface
REQ-001 SHALL have parameter AXI_ADDR_WIDTH, default 20, the address width of the traffic generator.
REQ-002 SHALL have parameter AXI_ID_WIDTH, default 4, the burst ID width.
REQ-003 SHALL use clock clk and reset rst_n, synchronous, active-low: clk input 1 system clock; rst_n input 1 synchronous active-low reset.
REQ-004 SHALL have these run-control ports: start input 1 launch run; abort input 1 stop run after the current phase; mode input 2 (0 write-only, 1 read-only, 2 write-then-read, 3 concurrent); iterations input 16 run count.
REQ-005 SHALL have these run-configuration ports: base_addr input AXI_ADDR_WIDTH first-iteration address; iter_step input AXI_ADDR_WIDTH per-iteration address increment; burst_id input AXI_ID_WIDTH; burst_beats input 8; burst_stride input AXI_ADDR_WIDTH; burst_size input 3; burst_num input 16.
REQ-006 SHALL have these generator-side ports: w_start output 1; r_start output 1; tgen_busy input 1; w_base_addr, r_base_addr output AXI_ADDR_WIDTH; w_burst_id, r_burst_id output AXI_ID_WIDTH; w_burst_beats, r_burst_beats output 8; w_burst_stride, r_burst_stride output AXI_ADDR_WIDTH; w_burst_awsize, r_burst_arsize output 3; w_burst_num, r_burst_num output 16.
REQ-007 SHALL have these status ports: busy output 1; done output 1 single-cycle completion pulse; aborted output 1; iter_count output 16 completed iterations; w_cycles, r_cycles output 32 accumulated phase cycles.

Function
REQ-008 SHALL implement the states IDLE, LAUNCH, WAIT, NEXT, DONE.
REQ-009 SHALL accept start only in IDLE, latching every configuration input and clearing iter_count, aborted, w_cycles and r_cycles; start in any other state SHALL be ignored.
REQ-010 SHALL go IDLE->DONE when start is accepted with iterations==0, and IDLE->LAUNCH otherwise; busy SHALL be high in every state except IDLE.
REQ-011 SHALL hold all generator configuration outputs stable from LAUNCH until the phase ends, and drive both w_* and r_* configuration from the latched values.
REQ-012 SHALL drive w_base_addr and r_base_addr as base_addr + iter_count*iter_step, computed by incremental addition modulo 2^AXI_ADDR_WIDTH so that it wraps silently.
REQ-013 LAUNCH SHALL last one cycle and pulse the starts for that one cycle: w_start for mode 0, mode 2 write phase and mode 3; r_start for mode 1, mode 2 read phase and mode 3, with mode 3 pulsing both together.
REQ-014 WAIT SHALL ignore tgen_busy on its first cycle, then exit when tgen_busy==0.
REQ-015 WAIT exit SHALL go to LAUNCH with the read phase in mode 2 after a write phase, and to NEXT otherwise.
REQ-016 NEXT SHALL increment iter_count (saturating at 16'hFFFF), then go to DONE if iter_count+1==iterations or if the abort flag is set, and to LAUNCH otherwise.
REQ-017 abort sampled high while busy SHALL set a sticky abort flag; the current phase SHALL still complete with no further starts, and on reaching DONE aborted SHALL be 1.
REQ-018 A mode 2 iteration aborted after its write phase SHALL skip the read phase and SHALL NOT be counted in iter_count.
REQ-019 DONE SHALL last one cycle, assert done, then go to IDLE; iter_count, aborted and the cycle counters SHALL hold until the next accepted start.
REQ-020 start and abort high in the same IDLE cycle SHALL start the run and ignore abort.

Reset
REQ-021 On rst_n==0 the state SHALL be IDLE and w_start, r_start, busy, done, aborted, iter_count, w_cycles, r_cycles and all configuration outputs SHALL be 0.
REQ-022 A reset mid-run SHALL take effect on the next clk edge with no start pulse emitted afterwards.

Configuration
REQ-023 With SVC_AXI_TGEN_CTRL_PERF_EN defined, w_cycles SHALL count +1 per WAIT cycle of a write or concurrent phase and r_cycles +1 per WAIT cycle of a read or concurrent phase, saturating at 32'hFFFFFFFF.
REQ-024 With SVC_AXI_TGEN_CTRL_PERF_EN undefined, w_cycles and r_cycles SHALL be constant 0 with no counter logic.

Verification
REQ-025 After reset with no start: busy=0, done=0, w_start=r_start=0, all outputs 0.
REQ-026 mode=0, iterations=3, base_addr=0x100, iter_step=0x40, model busy 5 cycles -> three w_start pulses with w_base_addr 0x100, 0x140, 0x180; no r_start; one done pulse; iter_count=3.
REQ-027 mode=2, iterations=2 -> start order w, r, w, r; no two starts in the same cycle; done once; iter_count=2.
REQ-028 mode=3, iterations=1 -> w_start and r_start in the same cycle; with PERF_EN and busy 4 cycles, w_cycles=r_cycles=4.
REQ-029 base_addr=0xFFFC0, iter_step=0x40, iterations=2, AXI_ADDR_WIDTH=20 -> second iteration address 0x00000.
REQ-030 mode=2, iterations=5, abort during first write WAIT -> no r_start, done after that write phase ends, aborted=1, iter_count=0; start during the run ignored.
